// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and constants for the dual-clock FIFO and its
// read-side streamer.
//   data_t           - FIFO word type
//   BURST_LEN_DEF    - default burst length of the read streamer
//   rd_strm_state_t  - read streamer FSM states
//   rd_credit_ok     - skid-buffer credit check used before issuing a pop
package fifo_pkg;

  localparam int DATA_W = 8;
  typedef logic [DATA_W-1:0] data_t;

  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_strm_state_t;

  // A new pop is safe when the words already owed to the skid buffer
  // (stored minus leaving this cycle, plus the one still in the RAM read
  // pipe) leave room for one more.
  function automatic logic rd_credit_ok(input logic [1:0] occ,
                                        input logic       deq,
                                        input logic       inflight);
    logic [2:0] owed;
    owed = {1'b0, occ} - {2'b00, deq} + {2'b00, inflight};
    return (owed <= 3'd1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: 2-entry register FIFO that absorbs the FIFO RAM read
// latency. No bypass: a written word is first visible on rd_data the cycle
// after it is written.
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr, wr_data - write strobe and word
//   rd          - consume the head entry (ignored when empty)
//   rd_data     - head entry
//   occ         - number of stored entries (0..2)
module fifo_rd_skid_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  data_t      wr_data,
  input  logic       rd,
  output data_t      rd_data,
  output logic [1:0] occ
);

  data_t      ent0_r;  // head
  data_t      ent1_r;  // second entry
  logic [1:0] occ_r;
  logic       rd_s;

  assign rd_s    = rd & (occ_r != 2'd0);
  assign rd_data = ent0_r;
  assign occ     = occ_r;

  // Entry storage and occupancy; the head only moves on a read or on a write into an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_r <= '0;
      ent1_r <= '0;
      occ_r  <= 2'd0;
    end else begin
      case ({wr, rd_s})
        2'b10: begin
          case (occ_r)
            2'd0: begin
              ent0_r <= wr_data;
              occ_r  <= 2'd1;
            end
            2'd1: begin
              ent1_r <= wr_data;
              occ_r  <= 2'd2;
            end
            default: begin
              // Full: the credit logic upstream keeps this from happening.
              occ_r <= occ_r;
            end
          endcase
        end
        2'b01: begin
          ent0_r <= ent1_r;
          occ_r  <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            ent0_r <= wr_data;
          end else begin
            ent0_r <= ent1_r;
            ent1_r <= wr_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side consumer of the dual-clock FIFO. Pops words
// while the FIFO is non-empty and the skid buffer has credit, and presents
// them as a valid/ready stream framed into bursts of BURST_LEN words.
//   rd_clk, rd_rst     - read clock, asynchronous active-low reset
//   en                 - run request; dropping it stops on a burst boundary
//   fifo_empty         - FIFO empty flag
//   fifo_data          - FIFO read data, valid the cycle after fifo_pop
//   fifo_pop           - pop strobe to the FIFO
//   m_valid, m_ready   - stream handshake
//   m_data, m_last     - stream word and end-of-burst marker
//   busy               - FSM not idle
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic  rd_clk,
  input  logic  rd_rst,
  input  logic  en,
  input  logic  fifo_empty,
  input  data_t fifo_data,
  output logic  fifo_pop,
  output logic  m_valid,
  input  logic  m_ready,
  output data_t m_data,
  output logic  m_last,
  output logic  busy
);

  localparam int               CNT_W   = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

  rd_strm_state_t   state_r;
  rd_strm_state_t   state_s;
  logic             inflight_r;
  logic [CNT_W-1:0] pop_cnt_r;
  logic [CNT_W-1:0] out_cnt_r;
  logic [1:0]       occ_s;
  logic             deq_s;
  logic             pop_allowed_s;
  logic             pop_s;

  // The RAM word popped last cycle is captured here; m_data is the head entry.
  fifo_rd_skid_buf u_skid (
    .clk     (rd_clk),
    .rst_n   (rd_rst),
    .wr      (inflight_r),
    .wr_data (fifo_data),
    .rd      (deq_s),
    .rd_data (m_data),
    .occ     (occ_s)
  );

  assign m_valid  = (occ_s != 2'd0);
  assign deq_s    = m_valid & m_ready;
  assign pop_s    = ~fifo_empty & pop_allowed_s & rd_credit_ok(occ_s, deq_s, inflight_r);
  assign fifo_pop = pop_s;
  assign m_last   = (out_cnt_r == CNT_MAX);
  assign busy     = (state_r != IDLE);

  // Next-state and pop permission; DRAIN keeps popping only to finish a started burst.
  always_comb begin
    state_s       = state_r;
    pop_allowed_s = 1'b0;
    case (state_r)
      IDLE: begin
        pop_allowed_s = 1'b0;
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        pop_allowed_s = 1'b1;
        if (!en) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        pop_allowed_s = (pop_cnt_r != '0);
        if (en) begin
          state_s = RUN;
        end else if ((pop_cnt_r == '0) && !inflight_r && (occ_s == 2'd0) && (out_cnt_r == '0)) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        pop_allowed_s = 1'b0;
        state_s       = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // RAM read-latency tracker and the two burst counters (mod BURST_LEN).
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      inflight_r <= 1'b0;
      pop_cnt_r  <= '0;
      out_cnt_r  <= '0;
    end else begin
      inflight_r <= pop_s;
      if (pop_s) begin
        pop_cnt_r <= (pop_cnt_r == CNT_MAX) ? '0 : pop_cnt_r + 1'b1;
      end
      if (deq_s) begin
        out_cnt_r <= (out_cnt_r == CNT_MAX) ? '0 : out_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed + randomized bench for fifo_rd_streamer.
// The bench plays the FIFO (a queue) and keeps a word-level reference model:
// every popped word is owed to the stream in order, becomes visible two
// cycles after its pop, and every BURST_LEN-th delivered word is a last.
module tb_fifo_rd_streamer;

  localparam int BL = 4;

  logic           rd_clk = 1'b0;
  logic           rd_rst;
  logic           en;
  logic           fifo_empty;
  fifo_pkg::data_t fifo_data;
  logic           fifo_pop;
  logic           m_valid;
  logic           m_ready;
  fifo_pkg::data_t m_data;
  logic           m_last;
  logic           busy;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_streamer #(.BURST_LEN(BL)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
  );

  int n_chk;
  int n_pass;
  int n_fail;

  logic [7:0] fq[$];      // FIFO contents
  logic [7:0] pend[$];    // popped, not yet delivered (in order)
  int         ptime[$];   // pop cycle of each pend entry
  int         pops;
  int         deliv;
  int         cyc;
  int         mode;       // 0 idle, 1 run, 2 drain
  logic [7:0] data_next;
  logic       en_v;
  logic       rdy_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    ptime.delete();
    pops  = 0;
    deliv = 0;
    mode  = 0;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
  endtask

  // One clock cycle: drive at negedge, check after settling, advance model.
  task automatic cycle();
    logic exp_valid;
    logic exp_deq;
    logic exp_pop;
    logic allowed;
    logic popped;
    int   outst;
    en         = en_v;
    m_ready    = rdy_v;
    fifo_empty = (fq.size() == 0);
    fifo_data  = data_next;
    #1;
    outst     = pend.size();
    exp_valid = 1'b0;
    if (outst != 0) exp_valid = (ptime[0] <= cyc - 2);
    exp_deq = exp_valid && rdy_v;
    case (mode)
      1:       allowed = 1'b1;
      2:       allowed = ((pops % BL) != 0);
      default: allowed = 1'b0;
    endcase
    exp_pop = !fifo_empty && allowed && ((outst - (exp_deq ? 1 : 0)) <= 1);
    chk("pop", fifo_pop, exp_pop);
    chk("valid", m_valid, exp_valid);
    chk("busy", busy, mode != 0);
    if (exp_valid) begin
      chk("data", m_data, pend[0]);
      chk("last", m_last, (deliv % BL) == (BL - 1));
    end
    popped = fifo_pop && (fq.size() != 0);
    case (mode)
      0: if (en_v) mode = 1;
      1: if (!en_v) mode = 2;
      2: begin
        if (en_v) mode = 1;
        else if ((pops % BL == 0) && (outst == 0) && (deliv % BL == 0)) mode = 0;
      end
      default: mode = 0;
    endcase
    if (exp_deq) begin
      void'(pend.pop_front());
      void'(ptime.pop_front());
      deliv++;
    end
    if (popped) begin
      data_next = fq.pop_front();
      pend.push_back(data_next);
      ptime.push_back(cyc);
      pops++;
    end else begin
      data_next = 8'($urandom);
    end
    cyc++;
    @(negedge rd_clk);
  endtask

  initial begin
    int  stall_left;
    int  p_start;
    bit  stalled;
    bit  dropped;
    bit  toggled;
    n_chk = 0; n_pass = 0; n_fail = 0;
    cyc = 0; en_v = 1'b0; rdy_v = 1'b1; data_next = 8'h00;
    model_reset();
    rd_rst = 1'b0; en = 1'b0; m_ready = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;
    #2;
    chk("rst_pop", fifo_pop, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge rd_clk);
    rd_rst = 1'b1;

    // Preloaded 8 words, full-rate streaming.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    en_v = 1'b1; rdy_v = 1'b1;
    repeat (14) cycle();
    chk("p1_deliv", deliv, 8);

    // 5-cycle stall once 0x11 of the second batch has been delivered.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    stalled = 1'b0; stall_left = 0; p_start = 0;
    for (int i = 0; i < 30; i++) begin
      if (!stalled && deliv == 10) begin
        stalled = 1'b1; stall_left = 5; p_start = pops;
      end
      rdy_v = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) chk("stall_pops_le2", (pops - p_start) <= 2, 1'b1);
      end
      cycle();
    end
    rdy_v = 1'b1;
    chk("stall_seen", stalled, 1'b1);
    chk("p2_deliv", deliv, 16);

    // en dropped after 2 pops of a burst: burst completes, then idle.
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    dropped = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!dropped && pops > 16 && (pops % BL) == 2) begin
        en_v = 1'b0; dropped = 1'b1;
      end
      cycle();
    end
    chk("drop_seen", dropped, 1'b1);
    chk("drop_pops", pops, 20);
    chk("drop_deliv", deliv, 20);
    chk("drop_idle", busy, 1'b0);
    chk("drop_left", fq.size(), 4);

    // FIFO empties mid-burst in DRAIN; one late word completes the burst.
    fq.delete();
    for (int i = 0; i < 3; i++) push(8'(8'h30 + i));
    en_v = 1'b1;
    repeat (8) cycle();
    en_v = 1'b0;
    repeat (10) cycle();
    chk("wait_busy", busy, 1'b1);
    chk("wait_pops", pops, 23);
    push(8'h33);
    repeat (10) cycle();
    chk("late_pops", pops, 24);
    chk("late_deliv", deliv, 24);
    chk("late_idle", busy, 1'b0);

    // Asynchronous reset mid-stall with words buffered.
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    en_v = 1'b1; rdy_v = 1'b0;
    repeat (4) cycle();
    rd_rst = 1'b0;
    #1;
    chk("arst_pop", fifo_pop, 1'b0);
    chk("arst_valid", m_valid, 1'b0);
    chk("arst_data", m_data, 8'h00);
    chk("arst_last", m_last, 1'b0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1; en_v = 1'b0; rdy_v = 1'b1;
    repeat (8) cycle();
    chk("arst_left", fq.size(), 4);

    // en re-raised while in DRAIN: burst framing continues.
    fq.delete();
    for (int i = 0; i < 12; i++) push(8'(8'h50 + i));
    en_v = 1'b1; toggled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!toggled && (pops % BL) == 1) begin
        en_v = 1'b0; toggled = 1'b1;
        cycle();
        chk("tog_drain_busy", busy, 1'b1);
        en_v = 1'b1;
      end
      cycle();
    end
    chk("tog_seen", toggled, 1'b1);
    chk("tog_pops", pops, 12);
    chk("tog_deliv", deliv, 12);

    // Randomized traffic, en toggling and backpressure.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15, 0) == 0) en_v = ~en_v;
      rdy_v = ($urandom_range(3, 0) != 0);
      if ($urandom_range(1, 0) == 1 && fq.size() < 16) push(8'($urandom));
      cycle();
    end
    en_v = 1'b0; rdy_v = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (fq.size() < 2) push(8'($urandom));
      cycle();
    end
    chk("final_idle", busy, 1'b0);
    chk("final_deliv", deliv, pops);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
